// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: fetch, load/store, memory and stall-enable signals of the shared-memory arbiter
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W/8-1:0] ram_wstrb;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ack;
  logic              pc_write;
  logic              if_id_write;
  logic              ex_mem_write;
  logic              timeout_err;
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, ram_rdata, ram_ack,
    output if_rdata, if_valid, mem_rdata, mem_valid, ram_req, ram_we, ram_addr, ram_wdata, ram_wstrb,
           pc_write, if_id_write, ex_mem_write, timeout_err
  );
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, ram_rdata, ram_ack,
    input  if_rdata, if_valid, mem_rdata, mem_valid, ram_req, ram_we, ram_addr, ram_wdata, ram_wstrb,
           pc_write, if_id_write, ex_mem_write, timeout_err
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported memory between fetch and load/store,
// sequencing req/ack accesses and producing structural-hazard stall enables.
module unified_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input logic clk,
  input logic rst_n,
  unified_mem_arbiter_if.slave bus
);
  localparam int SW = DATA_W / 8;
  localparam logic [7:0] LIM = 8'(MAX_WAIT - 1);
  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              ram_req_q, ram_req_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [SW-1:0]     ram_wstrb_q, ram_wstrb_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              mem_valid_q, mem_valid_d;
  logic              timeout_q, timeout_d;
  logic              finish, is_mem;
  assign is_mem = state_q == MEM_BUSY;
  assign finish = bus.ram_ack || cnt_q == LIM;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_wstrb_d = ram_wstrb_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_valid_d  = 1'b0;
    mem_valid_d = 1'b0;
    timeout_d   = timeout_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // MEM wins: it belongs to the older instruction further down the pipe
        if (bus.mem_req) begin
          state_d     = MEM_BUSY;
          ram_req_d   = 1'b1;
          ram_we_d    = bus.mem_we;
          ram_addr_d  = bus.mem_addr;
          ram_wdata_d = bus.mem_wdata;
          ram_wstrb_d = bus.mem_wstrb;
        end else if (bus.if_req) begin
          state_d     = IF_BUSY;
          ram_req_d   = 1'b1;
          ram_we_d    = 1'b0;
          ram_addr_d  = bus.if_addr;
          ram_wdata_d = '0;
          ram_wstrb_d = '0;
        end
      end
      IF_BUSY, MEM_BUSY: begin
        if (finish) begin
          state_d     = DONE;
          ram_req_d   = 1'b0;
          if_valid_d  = !is_mem;
          mem_valid_d = is_mem;
          timeout_d   = timeout_q | !bus.ram_ack;
          if (!is_mem) if_rdata_d = bus.ram_ack ? bus.ram_rdata : '0;
          else if (!bus.ram_ack || !ram_we_q) mem_rdata_d = bus.ram_ack ? bus.ram_rdata : '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_wstrb_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_wstrb_q <= ram_wstrb_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_valid_q  <= if_valid_d;
      mem_valid_q <= mem_valid_d;
      timeout_q   <= timeout_d;
    end
  end
  logic if_stall, mem_stall;
  assign if_stall         = bus.if_req & ~if_valid_q;
  assign mem_stall        = bus.mem_req & ~mem_valid_q;
  assign bus.pc_write     = ~(if_stall | mem_stall);
  assign bus.if_id_write  = ~(if_stall | mem_stall);
  assign bus.ex_mem_write = ~mem_stall;
  assign bus.ram_req      = ram_req_q;
  assign bus.ram_we       = ram_we_q;
  assign bus.ram_addr     = ram_addr_q;
  assign bus.ram_wdata    = ram_wdata_q;
  assign bus.ram_wstrb    = ram_wstrb_q;
  assign bus.if_rdata     = if_rdata_q;
  assign bus.if_valid     = if_valid_q;
  assign bus.mem_rdata    = mem_rdata_q;
  assign bus.mem_valid    = mem_valid_q;
  assign bus.timeout_err  = timeout_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed scoreboard bench; tasks push expected read data, a negedge monitor pops and compares.
module tb_unified_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  unified_mem_arbiter_if ifc ();
  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));
  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] q_if[$];
  logic [31:0] q_mem[$];
  logic [31:0] ram_m[logic [31:0]];
  logic ack_en = 1'b1;
  logic ack_force = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  // memory model: single-cycle ack while enabled, byte-strobed writes
  always @(negedge clk) begin
    ifc.ram_ack = ack_force | (ack_en & ifc.ram_req);
    ifc.ram_rdata = ram_m.exists(ifc.ram_addr) ? ram_m[ifc.ram_addr] : 32'h0;
    if (ifc.ram_ack && ifc.ram_req && ifc.ram_we) begin
      logic [31:0] w;
      w = ifc.ram_rdata;
      for (int b = 0; b < 4; b++) if (ifc.ram_wstrb[b]) w[b*8 +: 8] = ifc.ram_wdata[b*8 +: 8];
      ram_m[ifc.ram_addr] = w;
    end
  end
  always @(negedge clk) begin
    if (rst_n && ifc.if_valid) begin
      if (q_if.size() == 0) chk("if_valid_unexpected", 32'd1, 32'd0);
      else chk("if_rdata", ifc.if_rdata, q_if.pop_front());
    end
    if (rst_n && ifc.mem_valid) begin
      if (q_mem.size() == 0) chk("mem_valid_unexpected", 32'd1, 32'd0);
      else chk("mem_rdata", ifc.mem_rdata, q_mem.pop_front());
    end
  end
  task automatic fetch(input logic [31:0] a, input logic [31:0] exp, output int lat, output int busy);
    bit ok = 0;
    q_if.push_back(exp);
    ifc.if_req = 1'b1;
    ifc.if_addr = a;
    lat = 0;
    busy = 0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      lat++;
      if (ifc.ram_req) begin
        busy++;
        chk("if_ram_addr", ifc.ram_addr, a);
        chk("if_ram_we", 32'(ifc.ram_we), 32'd0);
        chk("if_pc_write", 32'(ifc.pc_write), 32'd0);
      end
      ok = ifc.if_valid;
    end
    if (!ok) chk("if_wait_timeout", 32'd0, 32'd1);
    ifc.if_req = 1'b0;
  endtask
  task automatic mem_access(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                            input logic [31:0] exp, output int busy);
    bit ok = 0;
    q_mem.push_back(exp);
    ifc.mem_req = 1'b1;
    ifc.mem_we = we;
    ifc.mem_addr = a;
    ifc.mem_wdata = wd;
    ifc.mem_wstrb = ws;
    busy = 0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (ifc.ram_req) begin
        busy++;
        chk("mem_ram_addr", ifc.ram_addr, a);
        chk("mem_ram_we", 32'(ifc.ram_we), 32'(we));
        if (we) begin
          chk("mem_ram_wdata", ifc.ram_wdata, wd);
          chk("mem_ram_wstrb", 32'(ifc.ram_wstrb), 32'(ws));
        end
        chk("mem_ex_mem_write", 32'(ifc.ex_mem_write), 32'd0);
      end
      ok = ifc.mem_valid;
    end
    if (!ok) chk("mem_wait_timeout", 32'd0, 32'd1);
    ifc.mem_req = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat, busy, gap;
    bit mem_done, if_done;
    ifc.if_req = 0; ifc.if_addr = 0; ifc.mem_req = 0; ifc.mem_we = 0;
    ifc.mem_addr = 0; ifc.mem_wdata = 0; ifc.mem_wstrb = 0;
    ifc.ram_ack = 0; ifc.ram_rdata = 0;
    ram_m[32'h100]  = 32'h00500093;
    ram_m[32'h104]  = 32'h00A00113;
    ram_m[32'h2000] = 32'hCAFEF00D;
    repeat (3) @(negedge clk);
    chk("rst_ram_req", 32'(ifc.ram_req), 32'd0);
    chk("rst_ram_addr", ifc.ram_addr, 32'd0);
    chk("rst_if_rdata", ifc.if_rdata, 32'd0);
    chk("rst_mem_rdata", ifc.mem_rdata, 32'd0);
    chk("rst_timeout", 32'(ifc.timeout_err), 32'd0);
    chk("rst_enables", {29'd0, ifc.pc_write, ifc.if_id_write, ifc.ex_mem_write}, 32'd7);
    rst_n = 1'b1;
    @(negedge clk);
    fetch(32'h100, 32'h00500093, lat, busy);
    chk("fetch_latency", 32'(lat), 32'd2);
    chk("fetch_busy", 32'(busy), 32'd1);
    chk("idle_enables", {29'd0, ifc.pc_write, ifc.if_id_write, ifc.ex_mem_write}, 32'd7);
    // simultaneous requests: MEM first, IF three cycles after mem_valid
    q_mem.push_back(32'hCAFEF00D);
    q_if.push_back(32'h00A00113);
    ifc.mem_req = 1; ifc.mem_we = 0; ifc.mem_addr = 32'h2000;
    ifc.if_req = 1; ifc.if_addr = 32'h104;
    mem_done = 0; if_done = 0; gap = 0;
    for (int n = 0; n < 40 && !if_done; n++) begin
      @(negedge clk);
      if (mem_done) gap++;
      if (!mem_done && !ifc.mem_valid) begin
        chk("dual_ex_mem_write", 32'(ifc.ex_mem_write), 32'd0);
        chk("dual_pc_write", 32'(ifc.pc_write), 32'd0);
      end
      if (ifc.if_valid) begin
        chk("dual_mem_first", 32'(mem_done), 32'd1);
        if_done = 1; ifc.if_req = 0;
      end
      if (ifc.mem_valid) begin
        mem_done = 1; ifc.mem_req = 0;
      end
    end
    chk("dual_completed", 32'(if_done), 32'd1);
    chk("dual_if_gap", 32'(gap), 32'd3);
    @(negedge clk);
    mem_access(1'b1, 32'h2000, 32'hDEADBEEF, 4'b0011, 32'hCAFEF00D, busy);
    chk("store_busy", 32'(busy), 32'd1);
    @(negedge clk);
    mem_access(1'b0, 32'h2000, 32'h0, 4'b0000, 32'hCAFEBEEF, busy);
    // ack while idle must not start or finish anything
    ack_force = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ack_ram_req", 32'(ifc.ram_req), 32'd0);
      chk("idle_ack_valids", {30'd0, ifc.if_valid, ifc.mem_valid}, 32'd0);
    end
    ack_force = 1'b0;
    @(negedge clk);
    ack_en = 1'b0;
    mem_access(1'b0, 32'h3000, 32'h0, 4'b0000, 32'h0, busy);
    chk("timeout_busy_cycles", 32'(busy), 32'd4);
    chk("timeout_err_set", 32'(ifc.timeout_err), 32'd1);
    ack_en = 1'b1;
    @(negedge clk);
    fetch(32'h104, 32'h00A00113, lat, busy);
    chk("timeout_err_sticky", 32'(ifc.timeout_err), 32'd1);
    // reset while MEM access outstanding
    @(negedge clk);
    ack_en = 1'b0;
    ifc.mem_req = 1; ifc.mem_we = 0; ifc.mem_addr = 32'h2000;
    @(negedge clk);
    chk("pre_reset_ram_req", 32'(ifc.ram_req), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("async_reset_ram_req", 32'(ifc.ram_req), 32'd0);
    ifc.mem_req = 0;
    ack_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("reset_no_mem_valid", 32'(ifc.mem_valid), 32'd0);
    end
    rst_n = 1'b1;
    chk("reset_clears_timeout", 32'(ifc.timeout_err), 32'd0);
    @(negedge clk);
    fetch(32'h100, 32'h00500093, lat, busy);
    chk("post_reset_latency", 32'(lat), 32'd2);
    repeat (2) @(negedge clk);
    chk("if_queue_empty", 32'(q_if.size()), 32'd0);
    chk("mem_queue_empty", 32'(q_mem.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
